spy_fifo_wr_arbiter: RTL and testbench
======================================

# spy_fifo_wr_arbiter

Round-robin, packet-locked arbiter that shares the single write port of one spy-buffer dual-clock FIFO between NREQ source streams, all in the write-clock domain. Each accepted word is written to the FIFO tagged with its source index and end-of-packet flag, so the read side can demultiplex. Backpressure comes from the FIFO's full and almost-full flags; once granted, a source keeps the port until it delivers its last word.

## Interface
- NREQ, 4: number of requesters, 2..16.
- DSIZE, 32: payload width per requester.
- IDW, $clog2(NREQ): source-tag width, derived, not overridable.
- CNTW, 16: statistics counter width.
- clk  in  1  write-side clock; FIFO wclk is driven by the same net.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-source word valid.
- req_data  in  NREQ*DSIZE  per-source payload; source i occupies bits [i*DSIZE +: DSIZE].
- req_last  in  NREQ  per-source end-of-packet flag, qualified by req_valid.
- req_ready  out  NREQ  per-source accept; at most one bit set.
- fifo_wdata  out  IDW+1+DSIZE  word written to the FIFO, packed as {src_id, last, data}.
- fifo_winc  out  1  FIFO write strobe.
- fifo_wfull  in  1  FIFO full flag.
- fifo_walmostfull  in  1  FIFO almost-full flag; the FIFO ALMOSTFULL setting must be >= 2.
- grant_valid  out  1  a source currently owns the port.
- grant_id  out  IDW  index of the owning source.
- stat_words  out  NREQ*CNTW  per-source accepted-word counters.
- stat_stall  out  CNTW  cycles in BURST with the owner valid but not ready.

## Operation
- The FSM has two states, IDLE and BURST, plus an rr_ptr register.
- **IDLE**
  - If any req_valid is set and fifo_walmostfull=0, pick the first valid source at or after rr_ptr, scanning upward with wrap-around.
  - Load grant_id with that source and go to BURST.
  - Otherwise stay in IDLE.
  - req_ready is all zero in IDLE.
- **BURST**
  - req_ready[grant_id] = !fifo_walmostfull && !fifo_wfull.
  - A transfer occurs when req_valid[grant_id] and req_ready[grant_id] are both 1.
  - A transfer with req_last=1 moves the FSM to IDLE and sets rr_ptr = grant_id+1, wrapping modulo NREQ.
  - Valid on other sources is ignored until the owner finishes its packet; there is no preemption and no timeout.
- **FIFO write**
  - Each transfer registers fifo_wdata = {grant_id, req_last, req_data slice} and pulses fifo_winc for exactly one cycle.
  - fifo_winc is never asserted while fifo_wfull=1 at the cycle the write lands.
  - This is guaranteed by the almost-full gating plus the ALMOSTFULL >= 2 requirement.
- **Flags**
  - grant_valid = (state==BURST).
  - grant_id holds its last value in IDLE.
- **Reset**
  - Values: state=IDLE, rr_ptr=0, grant_id=0, grant_valid=0, req_ready=0, fifo_winc=0, fifo_wdata=0, all stat counters=0.
  - A reset in the middle of a packet drops the rest of that packet; the truncated packet already in the FIFO is not repaired.

## Timing
- Arbitration takes 1 cycle: a request seen in IDLE at cycle N gives req_ready at cycle N+1 at the earliest.
- Write latency is 1 cycle: a transfer at cycle T gives fifo_winc at T+1.
- Inside a packet, throughput is 1 word per cycle while almost-full is low.
- There is 1 idle cycle between consecutive packets for re-arbitration.
- If almost-full rises at cycle N, req_ready drops at cycle N (combinational); at most one registered write is still in flight at N+1.
- When a single-word packet (valid and last together) is accepted, the FSM returns to IDLE on the next cycle.

## Configuration
- Macro: SPY_ARB_STATS_EN.
- **Defined:** statistics are active.
  - stat_words[i] increments on every transfer from source i.
  - stat_stall increments on every BURST cycle with req_valid[grant_id]=1 and req_ready[grant_id]=0.
  - Both counters saturate at 2^CNTW-1 and are cleared only by rst.
- **Undefined:** the stat_* ports remain present but are tied to 0 and no counter logic is built.

## Structure
- Package spy_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - a function computing IDW from NREQ, returning 1 when NREQ is 2;
  - the fifo_wdata field offset constants.
- Sub-module rr_pick: a purely combinational round-robin priority picker with inputs req[NREQ] and ptr[IDW], and outputs any and idx[IDW]. It is instantiated once.

## Test plan
- **Single source:** NREQ=4, source 2 sends a 3-word packet 0xA,0xB,0xC (last on 0xC).
  - FIFO receives {2,0,0xA}, {2,0,0xB}, {2,1,0xC} on 3 consecutive fifo_winc pulses.
  - Afterwards rr_ptr=3 and the FSM is in IDLE.
- **Fairness:** all 4 sources hold valid continuously with 2-word packets, starting from reset.
  - Grant order is 0,1,2,3,0.
  - Packets never interleave in the FIFO, and there is exactly 1 gap cycle between packets.
- **Backpressure:** fifo_walmostfull is raised mid-packet for 5 cycles.
  - req_ready is 0 for those 5 cycles, no word is lost or duplicated, and stat_stall=5 with the macro defined.
- **Full guard:** hold fifo_wfull=1 from IDLE with requests pending.
  - No grant, no fifo_winc; when the flag is released, the grant goes to the source at rr_ptr.
- **Mid-packet reset:** assert rst after word 2 of a 4-word packet.
  - The next cycle shows every output at its reset value.
  - After rst deasserts, grant restarts from source 0.
- **Saturation:** with the macro defined and CNTW=4, send 20 words from source 1.
  - stat_words[1] stays at 15; without the macro it reads 0.

Source files
------------

// File: rtl/spy_arb_pkg.sv
// Shared types and field layout for the spy-buffer FIFO write-port arbiter.
package spy_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Source-tag width; a two-source arbiter still needs one tag bit.
  function automatic int calc_idw(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  // fifo_wdata layout, LSB first: {src_id, last, data}
  localparam int WD_DATA_LSB = 0;

  function automatic int wd_last_bit(input int dsize);
    return dsize;
  endfunction

  function automatic int wd_id_lsb(input int dsize);
    return dsize + 1;
  endfunction

endpackage

// File: rtl/spy_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick
  import spy_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  int j;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        any = 1'b1;
        idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/spy_fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter for the spy-buffer FIFO write port.
// SPY_ARB_STATS_EN builds the per-source word and stall counters.
module spy_fifo_wr_arbiter
  import spy_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 32,
  parameter int CNTW  = 16,
  localparam int IDW  = calc_idw(NREQ),
  localparam int WW   = IDW + 1 + DSIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [WW-1:0]         fifo_wdata,
  output logic                  fifo_winc,
  input  logic                  fifo_wfull,
  input  logic                  fifo_walmostfull,
  output logic                  grant_valid,
  output logic [IDW-1:0]        grant_id,
  output logic [NREQ*CNTW-1:0]  stat_words,
  output logic [CNTW-1:0]       stat_stall
);

  localparam int LAST_BIT = wd_last_bit(DSIZE);
  localparam int ID_LSB   = wd_id_lsb(DSIZE);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  arb_state_e       state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   grant_id_q;
  logic [WW-1:0]    fifo_wdata_q;
  logic [WW-1:0]    fifo_wdata_d;
  logic             fifo_winc_q;

  logic             pick_any;
  logic [IDW-1:0]   pick_idx;
  logic             port_open;
  logic             own_valid;
  logic             own_last;
  logic [DSIZE-1:0] own_data;
  logic             xfer;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // A full FIFO also blocks arbitration, not just almost-full.
  assign port_open = !fifo_walmostfull && !fifo_wfull;
  assign own_valid = req_valid[grant_id_q];
  assign own_last  = req_last[grant_id_q];
  assign own_data  = req_data[grant_id_q*DSIZE +: DSIZE];
  assign xfer      = (state_q == BURST) && own_valid && port_open;

  always_comb begin
    req_ready = '0;
    if (state_q == BURST) req_ready[grant_id_q] = port_open;
  end

  always_comb begin
    fifo_wdata_d = '0;
    fifo_wdata_d[ID_LSB +: IDW]        = grant_id_q;
    fifo_wdata_d[LAST_BIT]             = own_last;
    fifo_wdata_d[WD_DATA_LSB +: DSIZE] = own_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      fifo_wdata_q <= '0;
      fifo_winc_q  <= 1'b0;
    end else begin
      fifo_winc_q <= xfer;
      if (xfer) fifo_wdata_q <= fifo_wdata_d;
      case (state_q)
        IDLE: begin
          if (pick_any && port_open) begin
            grant_id_q <= pick_idx;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (xfer && own_last) begin
            state_q  <= IDLE;
            rr_ptr_q <= (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wdata  = fifo_wdata_q;
  assign fifo_winc   = fifo_winc_q;
  assign grant_valid = (state_q == BURST);
  assign grant_id    = grant_id_q;

`ifdef SPY_ARB_STATS_EN
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0] words_q [NREQ];
  logic [CNTW-1:0] stall_q;
  logic            stall_hit;

  assign stall_hit = (state_q == BURST) && own_valid && !port_open;

  // Saturating counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) words_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer && (grant_id_q == IDW'(i)) && (words_q[i] != CNT_MAX))
          words_q[i] <= words_q[i] + 1'b1;
      end
      if (stall_hit && (stall_q != CNT_MAX)) stall_q <= stall_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_words[g*CNTW +: CNTW] = words_q[g];
  end
  assign stat_stall = stall_q;
`else
  assign stat_words = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_spy_fifo_wr_arbiter.sv
// Directed bench for spy_fifo_wr_arbiter (NREQ=4, DSIZE=32, CNTW=4).
module tb_spy_fifo_wr_arbiter;

`ifdef SPY_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic [34:0]  fifo_wdata;
  logic         fifo_winc;
  logic         fifo_wfull;
  logic         fifo_walmostfull;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [15:0]  stat_words;
  logic [3:0]   stat_stall;

  int n_assert = 0;
  int n_fail   = 0;

  // Fairness run, cycles 0..14 after reset
  int f_gv   [15] = '{0,1,1,0,1,1,0,1,1,0,1,1,0,1,1};
  int f_gid  [15] = '{0,0,0,0,1,1,0,2,2,0,3,3,0,0,0};
  int f_winc [15] = '{0,0,1,1,0,1,1,0,1,1,0,1,1,0,1};
  int f_wsrc [15] = '{0,0,0,0,0,1,1,0,2,2,0,3,3,0,0};
  int f_wlst [15] = '{0,0,0,1,0,0,1,0,0,1,0,0,1,0,0};

  // Backpressure run, source 1 six-word packet, cycles 0..13
  int b_af   [14] = '{0,0,0,1,1,1,1,1,0,0,0,0,0,0};
  int b_rdy  [14] = '{0,1,1,0,0,0,0,0,1,1,1,1,0,0};
  int b_winc [14] = '{0,0,1,1,0,0,0,0,0,1,1,1,1,0};
  int b_wd   [14] = '{0,0,0,1,0,0,0,0,0,2,3,4,5,0};

  spy_fifo_wr_arbiter #(.NREQ(4), .DSIZE(32), .CNTW(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .fifo_wdata       (fifo_wdata),
    .fifo_winc        (fifo_winc),
    .fifo_wfull       (fifo_wfull),
    .fifo_walmostfull (fifo_walmostfull),
    .grant_valid      (grant_valid),
    .grant_id         (grant_id),
    .stat_words       (stat_words),
    .stat_stall       (stat_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_src(input int i, input bit v, input bit l, input logic [31:0] d);
    req_valid[i]        = v;
    req_last[i]         = l;
    req_data[i*32 +: 32] = d;
  endtask

  function automatic logic [63:0] wexp(input int id, input bit last, input logic [31:0] d);
    return (64'(id) << 33) | (64'(last) << 32) | 64'(d);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    fifo_wfull = 1'b0; fifo_walmostfull = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int  w;
    int  cyc;
    bit  acc;
    bit  phase [4];
    bit  facc [4];

    // ---- reset values
    do_reset();
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_winc", fifo_winc, 0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_swords", stat_words, 0);
    chk("rst_sstall", stat_stall, 0);

    // ---- single source, 3-word packet from source 2
    drive_src(2, 1, 0, 32'hA); settle();
    chk("t1_idle_ready", req_ready, 0);
    step();
    settle();
    chk("t1_gv", grant_valid, 1);
    chk("t1_gid", grant_id, 2);
    chk("t1_ready", req_ready, 4'b0100);
    chk("t1_winc0", fifo_winc, 0);
    step();
    chk("t1_winc_a", fifo_winc, 1);
    chk("t1_wdata_a", fifo_wdata, wexp(2, 0, 32'hA));
    drive_src(2, 1, 0, 32'hB);
    step();
    chk("t1_winc_b", fifo_winc, 1);
    chk("t1_wdata_b", fifo_wdata, wexp(2, 0, 32'hB));
    drive_src(2, 1, 1, 32'hC);
    step();
    chk("t1_winc_c", fifo_winc, 1);
    chk("t1_wdata_c", fifo_wdata, wexp(2, 1, 32'hC));
    chk("t1_idle_gv", grant_valid, 0);
    chk("t1_gid_hold", grant_id, 2);
    drive_src(2, 0, 0, 32'h0);
    step();
    chk("t1_winc_end", fifo_winc, 0);
    for (int i = 0; i < 4; i++) drive_src(i, 1, 1, 32'h300 + i);
    step();
    settle();
    chk("t1_rrptr_gid", grant_id, 3);
    chk("t1_rrptr_ready", req_ready, 4'b1000);
    step();
    chk("t1_single_winc", fifo_winc, 1);
    chk("t1_single_wdata", fifo_wdata, wexp(3, 1, 32'h303));
    chk("t1_single_idle", grant_valid, 0);
    req_valid = '0;
    step();

    // ---- fairness: all sources, 2-word packets
    do_reset();
    for (int i = 0; i < 4; i++) phase[i] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < 4; i++) drive_src(i, 1, phase[i], 32'(256 * i + int'(phase[i])));
      settle();
      chk($sformatf("t2_gv_c%0d", c), grant_valid, f_gv[c]);
      if (f_gv[c] != 0) chk($sformatf("t2_gid_c%0d", c), grant_id, f_gid[c]);
      chk($sformatf("t2_winc_c%0d", c), fifo_winc, f_winc[c]);
      if (f_winc[c] != 0)
        chk($sformatf("t2_wdata_c%0d", c), fifo_wdata,
            wexp(f_wsrc[c], f_wlst[c] != 0, 32'(256 * f_wsrc[c] + f_wlst[c])));
      for (int i = 0; i < 4; i++) facc[i] = req_ready[i] && req_valid[i];
      step();
      for (int i = 0; i < 4; i++) if (facc[i]) phase[i] = ~phase[i];
    end
    req_valid = '0;
    step();

    // ---- backpressure: almost-full for 5 cycles mid-packet
    do_reset();
    w = 0;
    for (int c = 0; c < 14; c++) begin
      fifo_walmostfull = (b_af[c] != 0);
      if (w <= 5) drive_src(1, 1, w == 5, 32'h50 + w);
      else drive_src(1, 0, 0, 32'h0);
      settle();
      chk($sformatf("t3_ready_c%0d", c), req_ready, (b_rdy[c] != 0) ? 4'b0010 : 4'b0000);
      chk($sformatf("t3_winc_c%0d", c), fifo_winc, b_winc[c]);
      if (b_winc[c] != 0)
        chk($sformatf("t3_wdata_c%0d", c), fifo_wdata,
            wexp(1, b_wd[c] == 5, 32'h50 + b_wd[c]));
      acc = req_ready[1] && req_valid[1];
      step();
      if (acc) w++;
    end
    chk("t3_sstall", stat_stall, STATS ? 5 : 0);
    chk("t3_swords", stat_words, STATS ? 16'h0060 : 16'h0000);

    // ---- full guard: rr_ptr is now 2
    fifo_wfull = 1'b1;
    for (int i = 0; i < 4; i++) drive_src(i, 1, 1, 32'h400 + i);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("t4_gv_c%0d", c), grant_valid, 0);
      chk($sformatf("t4_winc_c%0d", c), fifo_winc, 0);
      chk($sformatf("t4_ready_c%0d", c), req_ready, 0);
      step();
    end
    fifo_wfull = 1'b0;
    settle();
    chk("t4_still_idle", grant_valid, 0);
    step();
    settle();
    chk("t4_gv", grant_valid, 1);
    chk("t4_gid", grant_id, 2);
    chk("t4_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("t4_winc", fifo_winc, 1);
    chk("t4_wdata", fifo_wdata, wexp(2, 1, 32'h402));
    step();

    // ---- mid-packet reset, source 3 four-word packet
    drive_src(3, 1, 0, 32'h60);
    step();
    chk("t5_gid", grant_id, 3);
    chk("t5_gv", grant_valid, 1);
    step();
    drive_src(3, 1, 0, 32'h61);
    step();
    rst = 1'b1;
    drive_src(3, 1, 0, 32'h62);
    settle();
    chk("t5_winc_w1", fifo_winc, 1);
    chk("t5_wdata_w1", fifo_wdata, wexp(3, 0, 32'h61));
    step();
    settle();
    chk("t5_rst_gv", grant_valid, 0);
    chk("t5_rst_gid", grant_id, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_winc", fifo_winc, 0);
    chk("t5_rst_wdata", fifo_wdata, 0);
    chk("t5_rst_swords", stat_words, 0);
    chk("t5_rst_sstall", stat_stall, 0);
    for (int i = 0; i < 4; i++) drive_src(i, 1, 1, 32'h500 + i);
    step();
    rst = 1'b0;
    settle();
    chk("t5_hold_idle", grant_valid, 0);
    step();
    chk("t5_restart_gv", grant_valid, 1);
    chk("t5_restart_gid", grant_id, 0);
    step();
    req_valid = '0;
    step();

    // ---- saturation: 20 words from source 1
    do_reset();
    w = 0;
    cyc = 0;
    while (w < 20 && cyc < 60) begin
      drive_src(1, 1, w == 19, 32'h700 + w);
      settle();
      acc = req_ready[1] && req_valid[1];
      step();
      if (acc) w++;
      cyc++;
    end
    drive_src(1, 0, 0, 32'h0);
    chk("t6_words_sent", w, 20);
    step();
    step();
    chk("t6_swords", stat_words, STATS ? 16'h00F0 : 16'h0000);
    chk("t6_sstall", stat_stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
